// File: rtl/midi_pkg.sv
// midi_pkg: shared constants and state types for the MIDI receive path.
// - Status-nibble codes for Note Off / Note On
// - Lowest real-time status byte value
// - Parser and UART state enumerations
// - Helper that classifies a status byte as a note message
package midi_pkg;

  localparam logic [3:0] NOTE_OFF  = 4'h8;
  localparam logic [3:0] NOTE_ON   = 4'h9;
  localparam logic [7:0] RT_THRESH = 8'hF8;

  typedef enum logic [1:0] {
    WAIT_STATUS = 2'd0,
    WAIT_NOTE   = 2'd1,
    WAIT_VEL    = 2'd2
  } parse_state_t;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // True for 0x80..0x9F: the only channel messages this receiver tracks.
  function automatic logic is_note_status(input logic [7:0] b);
    return (b[7:4] == NOTE_OFF) || (b[7:4] == NOTE_ON);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 serial receiver with a 2-FF input synchroniser.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   rx         in   raw serial line, idle high
//   data_byte  out  received byte, valid while byte_valid is high
//   byte_valid out  one-cycle pulse, cycle after a good stop bit
//   frame_err  out  one-cycle pulse, cycle after a low stop bit
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int DIV = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = (DIV > 2) ? $clog2(DIV) : 2;
  localparam logic [TW-1:0] HALF = TW'(DIV / 2);
  localparam logic [TW-1:0] LAST = TW'(DIV - 1);

  logic          rx_meta_r;
  logic          rx_sync_r;
  uart_state_t   state_r;
  uart_state_t   state_s;
  logic [TW-1:0] timer_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic [7:0]    byte_r;
  logic          byte_valid_r;
  logic          frame_err_r;
  // Set after a low stop bit so a line stuck low cannot retrigger a frame.
  logic          line_low_r;

  logic          timer_clr_s;
  logic          bit_sample_s;
  logic          stop_ok_s;
  logic          stop_bad_s;

  // Two-stage synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // UART state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= UART_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // UART next-state and sampling strobes.
  always_comb begin
    state_s      = state_r;
    timer_clr_s  = 1'b0;
    bit_sample_s = 1'b0;
    stop_ok_s    = 1'b0;
    stop_bad_s   = 1'b0;
    case (state_r)
      UART_IDLE: begin
        timer_clr_s = 1'b1;
        if (!rx_sync_r && !line_low_r) begin
          state_s = UART_START;
        end else begin
          state_s = UART_IDLE;
        end
      end
      UART_START: begin
        // Mid-bit check of the start bit rejects short glitches.
        if (timer_r == HALF) begin
          timer_clr_s = 1'b1;
          if (rx_sync_r) begin
            state_s = UART_IDLE;
          end else begin
            state_s = UART_DATA;
          end
        end else begin
          state_s = UART_START;
        end
      end
      UART_DATA: begin
        if (timer_r == LAST) begin
          timer_clr_s  = 1'b1;
          bit_sample_s = 1'b1;
          if (bit_cnt_r == 3'd7) begin
            state_s = UART_STOP;
          end else begin
            state_s = UART_DATA;
          end
        end else begin
          state_s = UART_DATA;
        end
      end
      UART_STOP: begin
        if (timer_r == LAST) begin
          timer_clr_s = 1'b1;
          state_s     = UART_IDLE;
          if (rx_sync_r) begin
            stop_ok_s = 1'b1;
          end else begin
            stop_bad_s = 1'b1;
          end
        end else begin
          state_s = UART_STOP;
        end
      end
      default: begin
        state_s     = UART_IDLE;
        timer_clr_s = 1'b1;
      end
    endcase
  end

  // Bit timer, shift register, registered byte/flag outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r      <= '0;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      byte_r       <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      line_low_r   <= 1'b0;
    end else begin
      timer_r <= timer_clr_s ? '0 : timer_r + {{(TW-1){1'b0}}, 1'b1};
      if (bit_sample_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        shift_r   <= {rx_sync_r, shift_r[7:1]};
      end else if (state_r != UART_DATA) begin
        bit_cnt_r <= 3'd0;
      end
      if (stop_ok_s) begin
        byte_r <= shift_r;
      end
      byte_valid_r <= stop_ok_s;
      frame_err_r  <= stop_bad_s;
      if (stop_bad_s) begin
        line_low_r <= 1'b1;
      end else if (rx_sync_r) begin
        line_low_r <= 1'b0;
      end
    end
  end

  assign data_byte  = byte_r;
  assign byte_valid = byte_valid_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/tt_midi_rx.sv
// tt_midi_rx: MIDI input receiver; turns Note On/Off messages into
// one-cycle note events, with running-status support.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   rx         in   raw MIDI serial line (31250 baud, 8N1, idle high)
//   note_valid out  one-cycle event strobe
//   note_on    out  1 = Note On, 0 = Note Off (incl. Note On, velocity 0)
//   note_num   out  note number of the last event
//   velocity   out  velocity of the last event as received
//   channel    out  channel of the last event
//   frame_err  out  one-cycle pulse on a low stop bit
module tt_midi_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ   = 10_000_000,
  parameter int BAUD     = 31250,
  parameter int CHAN_ALL = 1,
  parameter int CHAN     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       note_valid,
  output logic       note_on,
  output logic [6:0] note_num,
  output logic [6:0] velocity,
  output logic [3:0] channel,
  output logic       frame_err
);

  localparam int DIV = CLK_HZ / BAUD;

  if ((DIV < 8) || ((CLK_HZ % BAUD) != 0)) begin : g_bad_div
    $error("tt_midi_rx: CLK_HZ/BAUD must be an integer >= 8");
  end

  logic [7:0]   data_byte_s;
  logic         byte_valid_s;

  parse_state_t pstate_r;
  parse_state_t pstate_s;
  logic [7:0]   status_r;
  logic [7:0]   status_s;
  logic [6:0]   note_r;
  logic [6:0]   note_s;
  logic         emit_s;
  logic         chan_ok_s;

  logic         note_valid_r;
  logic         note_on_r;
  logic [6:0]   note_num_r;
  logic [6:0]   velocity_r;
  logic [3:0]   channel_r;

  midi_uart_rx #(
    .DIV(DIV)
  ) u_uart (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_byte  (data_byte_s),
    .byte_valid (byte_valid_s),
    .frame_err  (frame_err)
  );

  // Parser state and running-status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate_r <= WAIT_STATUS;
      status_r <= 8'h00;
      note_r   <= 7'h00;
    end else begin
      pstate_r <= pstate_s;
      status_r <= status_s;
      note_r   <= note_s;
    end
  end

  // Parser next-state: one byte per byte_valid pulse.
  always_comb begin
    pstate_s = pstate_r;
    status_s = status_r;
    note_s   = note_r;
    emit_s   = 1'b0;
    if (byte_valid_s) begin
      if (data_byte_s >= RT_THRESH) begin
        // Real-time bytes may interleave anywhere and leave state untouched.
        pstate_s = pstate_r;
      end else if (data_byte_s[7]) begin
        // Any status byte abandons a partial message.
        if (is_note_status(data_byte_s)) begin
          status_s = data_byte_s;
          pstate_s = WAIT_NOTE;
        end else begin
          status_s = 8'h00;
          pstate_s = WAIT_STATUS;
        end
      end else begin
        case (pstate_r)
          WAIT_NOTE: begin
            note_s   = data_byte_s[6:0];
            pstate_s = WAIT_VEL;
          end
          WAIT_VEL: begin
            emit_s   = 1'b1;
            pstate_s = WAIT_NOTE;
          end
          default: begin
            pstate_s = WAIT_STATUS;
          end
        endcase
      end
    end else begin
      pstate_s = pstate_r;
    end
  end

  assign chan_ok_s = (CHAN_ALL != 0) || (status_r[3:0] == 4'(CHAN));

  // Registered event outputs; fields hold until the next accepted event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_valid_r <= 1'b0;
      note_on_r    <= 1'b0;
      note_num_r   <= 7'h00;
      velocity_r   <= 7'h00;
      channel_r    <= 4'h0;
    end else begin
      note_valid_r <= emit_s && chan_ok_s;
      if (emit_s && chan_ok_s) begin
        note_on_r  <= (status_r[7:4] == NOTE_ON) && (data_byte_s[6:0] != 7'h00);
        note_num_r <= note_r;
        velocity_r <= data_byte_s[6:0];
        channel_r  <= status_r[3:0];
      end
    end
  end

  assign note_valid = note_valid_r;
  assign note_on    = note_on_r;
  assign note_num   = note_num_r;
  assign velocity   = velocity_r;
  assign channel    = channel_r;

endmodule
